// File: rtl/psg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : psg_arb_pkg
// Purpose : Shared FSM encoding and PSG register constants for the arbiter.
// Revision: 1.0
// ============================================================================
package psg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [3:0] PSG_REG_ENV_SHAPE = 4'd13;

endpackage
`default_nettype wire

// File: rtl/psg_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module  : psg_arb_rr2
// Purpose : Two-way picker; round-robin against the last grant, or fixed
//           priority (requester 0) when rr_en is low.
// Revision: 1.0
// ============================================================================
module psg_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b10) begin
            grant = 1'b1;
        end else if (req == 2'b11) begin
            grant = rr_en ? ~last : 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : psg_access_arbiter
// Purpose : Arbitrates two requesters onto a single PSG register bus, with an
//           idle guard after envelope-shape writes.
// Revision: 1.0
// ============================================================================
module psg_access_arbiter
    import psg_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 1,
    parameter bit RR_ENABLE    = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [3:0] ADDR0,
    input  logic [3:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [7:0] RDATA,
    output logic       PSG_CS,
    output logic       PSG_WR,
    output logic [3:0] PSG_ADDR,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO,
    output logic       BUSY
);

    localparam bit         C_GUARD_EN   = (GUARD_CYCLES != 0);
    localparam logic [2:0] C_GUARD_LOAD = 3'(GUARD_CYCLES - 1);

    state_t     r_state;
    logic       r_last;
    logic       r_gnt;
    logic       r_we;
    logic [3:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_psg_cs;
    logic       r_psg_wr;
    logic       r_ack0;
    logic       r_ack1;
    logic [2:0] r_guard_cnt;

    logic [1:0] w_req;
    logic       w_pick;
    logic       w_start;
    logic       w_env;
    logic       w_sel_we;
    logic [3:0] w_sel_addr;
    logic [7:0] w_sel_wdata;

    psg_arb_rr2 u_rr2 (
        .req   (w_req),
        .last  (r_last),
        .rr_en (RR_ENABLE),
        .grant (w_pick)
    );

    assign w_req = {REQ1, REQ0};

    // No new grant in an ACK cycle: the acknowledged requester may still be
    // holding REQ, and this cycle is what gives the 3-cycle access cadence.
    assign w_start = (r_state == IDLE) && (|w_req) && !(r_ack0 || r_ack1);

    assign w_env       = C_GUARD_EN && r_we && (r_addr == PSG_REG_ENV_SHAPE);
    assign w_sel_we    = w_pick ? WE1    : WE0;
    assign w_sel_addr  = w_pick ? ADDR1  : ADDR0;
    assign w_sel_wdata = w_pick ? WDATA1 : WDATA0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 4'd0;
            r_wdata     <= 8'd0;
            r_rdata     <= 8'd0;
            r_psg_cs    <= 1'b0;
            r_psg_wr    <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_guard_cnt <= 3'd0;
        end else begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_psg_cs <= 1'b0;
            r_psg_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= ISSUE;
                        r_gnt    <= w_pick;
                        r_last   <= w_pick;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_psg_cs <= 1'b1;
                        r_psg_wr <= w_sel_we;
                    end
                end
                ISSUE: begin
                    r_ack0 <= ~r_gnt;
                    r_ack1 <= r_gnt;
                    if (!r_we) begin
                        r_rdata <= PSG_DO;
                    end
                    if (w_env) begin
                        r_state     <= GUARD;
                        r_guard_cnt <= C_GUARD_LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GUARD: begin
                    if (r_guard_cnt == 3'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ACK0     = r_ack0;
    assign ACK1     = r_ack1;
    assign RDATA    = r_rdata;
    assign PSG_CS   = r_psg_cs;
    assign PSG_WR   = r_psg_wr;
    assign PSG_ADDR = r_addr;
    assign PSG_DI   = r_wdata;
    assign BUSY     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/psg_access_arbiter.md
PSG_ACCESS_ARBITER -- requirements
Module: psg_access_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 1, idle cycles inserted after any write to PSG register 13 (envelope shape/restart); range 0..7.
REQ-002 Parameter RR_ENABLE, default 1; 1 = round-robin arbitration, 0 = fixed priority with requester 0 winning.
REQ-003 CLK  in  1  single clock for all logic.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 REQ0, REQ1  in  1 each  access request, held high until the matching ACK.
REQ-006 WE0, WE1  in  1 each  1 = write, 0 = read; stable while REQn is high.
REQ-007 ADDR0, ADDR1  in  4 each  PSG register index.
REQ-008 WDATA0, WDATA1  in  8 each  write data.
REQ-009 ACK0, ACK1  out  1 each  one-cycle completion pulse.
REQ-010 RDATA  out  8  read data, valid in the ACK cycle, held until the next read completes.
REQ-011 PSG_CS, PSG_WR  out  1 each  registered strobes to the PSG bus.
REQ-012 PSG_ADDR  out  4; PSG_DI  out  8  registered PSG address and write data.
REQ-013 PSG_DO  in  8  combinational PSG read data.
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, GUARD.
REQ-016 IDLE: if REQ0 or REQ1 is high, the block SHALL latch the winner, its WE, ADDR and WDATA on the next edge and enter ISSUE; otherwise it stays in IDLE.
REQ-017 Round-robin mode: on simultaneous requests, the requester not granted last SHALL win; the last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-018 ISSUE SHALL last exactly one cycle, with PSG_CS=1, PSG_WR=latched WE, and PSG_ADDR and PSG_DI driven from the latch.
REQ-019 PSG_CS and PSG_WR SHALL be 0 in every state except ISSUE; PSG_ADDR and PSG_DI hold their last values.
REQ-020 At the end of ISSUE, for a read, RDATA SHALL capture PSG_DO.
REQ-021 ACKn for the winner SHALL pulse for one cycle, in the cycle after ISSUE.
REQ-022 Latency: REQ sampled high at edge n gives ISSUE in cycle n+1 and ACK in cycle n+2.
REQ-023 After ISSUE, if the access was a write to ADDR 13 and GUARD_CYCLES>0, the FSM SHALL enter GUARD for exactly GUARD_CYCLES cycles, then go to IDLE; otherwise it goes directly to IDLE.
REQ-024 A REQ still high in the ACK cycle SHALL NOT be re-granted by that cycle's IDLE decision; the block SHALL mask ACKed requesters for one cycle.
REQ-025 Back-to-back sustained requests from one requester SHALL achieve one access per 3 cycles with no guard.
REQ-026 Both requesters continuously requesting SHALL alternate grants 0,1,0,1 in round-robin mode; in fixed mode requester 1 starves, which is accepted behaviour.
REQ-027 A request withdrawn before its grant is a protocol violation; the block needs no defined behaviour beyond not hanging.
REQ-028 Reads of ADDR 14/15 are ordinary reads; no special handling.

Reset
REQ-029 On RESET the block SHALL immediately enter IDLE, with PSG_CS=0, PSG_WR=0, PSG_ADDR=0, PSG_DI=0, RDATA=0, ACK0=ACK1=0, BUSY=0, last-grant=1 and the guard counter at 0.
REQ-030 RESET asserted mid-ISSUE SHALL abort the access with no ACK issued; the requester retries after reset.

Structure
REQ-031 Shared package psg_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, GUARD) and the constant PSG_REG_ENV_SHAPE=4'd13.
REQ-032 The 2-way round-robin picker SHALL be a sub-module, psg_arb_rr2, with inputs req[1:0], last and rr_en and output grant index; all other logic is flat.

Verification
REQ-033 Single write: REQ0=1, WE0=1, ADDR0=7, WDATA0=8'h38 at edge n -> PSG_CS=PSG_WR=1, PSG_ADDR=7, PSG_DI=8'h38 in cycle n+1 only; ACK0 pulses in n+2.
REQ-034 Read: REQ1=1, WE1=0, ADDR1=8, PSG model returns 8'h1F -> ACK1 in n+2 with RDATA=8'h1F; RDATA holds after REQ1 drops.
REQ-035 Contention: REQ0=REQ1=1 held with writes -> grant order 0,1,0,1 with ACK spacing of 3 cycles; with RR_ENABLE=0 only ACK0 pulses.
REQ-036 Envelope guard: write ADDR 13 with GUARD_CYCLES=3, REQ1 pending -> GUARD lasts 3 cycles, the next PSG_CS is 5 cycles after the reg-13 ISSUE, and BUSY stays high throughout.
REQ-037 Reset mid-op: assert RESET during ISSUE -> PSG_CS drops asynchronously, no ACK, FSM in IDLE, and the re-asserted request completes normally.
